// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared types and constants for the S-box lane arbiter.
//               Holds the arbiter FSM state encoding, the requester grant IDs,
//               the state-word index constants, the in-flight tracker entry,
//               and a helper that extracts one 32-bit column from a
//               128-bit AES state.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_KEY_ISSUE = 3'd1,
        S_DAT_ISSUE = 3'd2,
        S_DRAIN     = 3'd3,
        S_ACK       = 3'd4
    } state_e;

    typedef enum logic {
        GNT_KEY = 1'b0,
        GNT_DAT = 1'b1
    } grant_e;

    // Word 0 is the most significant column of the 128-bit state.
    localparam logic [1:0] c_WC_FIRST = 2'd0;
    localparam logic [1:0] c_WC_LAST  = 2'd3;

    // One entry per word travelling through the S-box lanes.
    typedef struct packed {
        logic       valid;
        logic       is_dat;
        logic       enc;
        logic [1:0] idx;
    } trk_t;

    function automatic logic [31:0] state_word(input logic [127:0] st,
                                               input logic [1:0]   idx);
        case (idx)
            2'd0:    state_word = st[127:96];
            2'd1:    state_word = st[95:64];
            2'd2:    state_word = st[63:32];
            default: state_word = st[31:0];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sbox_arbiter_if
// Description : Bundle of the requester handshakes and the S-box lane port.
//               slave  : arbiter view (takes requests, drives lanes and acks)
//               master : environment view (requesters plus lane outputs)
//   key_req/key_word/key_ack/key_result      : key-expansion SubWord port
//   dat_req/dat_state/dat_enc_dec/dat_ack/
//   dat_result                               : datapath SubBytes port
//   sbox_in/sbox_enc_dec/sbox_out_enc/
//   sbox_out_dec                             : shared S-box lane group
//   busy                                     : arbiter not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface sbox_arbiter_if;
    logic         key_req;
    logic [31:0]  key_word;
    logic         key_ack;
    logic [31:0]  key_result;
    logic         dat_req;
    logic [127:0] dat_state;
    logic         dat_enc_dec;
    logic         dat_ack;
    logic [127:0] dat_result;
    logic [31:0]  sbox_in;
    logic         sbox_enc_dec;
    logic [31:0]  sbox_out_enc;
    logic [31:0]  sbox_out_dec;
    logic         busy;

    modport slave (
        input  key_req, key_word, dat_req, dat_state, dat_enc_dec,
               sbox_out_enc, sbox_out_dec,
        output key_ack, key_result, dat_ack, dat_result,
               sbox_in, sbox_enc_dec, busy
    );

    modport master (
        output key_req, key_word, dat_req, dat_state, dat_enc_dec,
               sbox_out_enc, sbox_out_dec,
        input  key_ack, key_result, dat_ack, dat_result,
               sbox_in, sbox_enc_dec, busy
    );
endinterface
`default_nettype wire

// File: rtl/sbox_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : sbox_rr_arb
// Description : Two-requester grant logic (key vs. datapath). Combinational
//               grant decision plus the last_grant flop used for round-robin
//               tie breaking.
//   clk, rst        : clock, asynchronous active-high reset
//   key_req_i       : key requester level request
//   dat_req_i       : datapath requester level request
//   key_mask_i      : ignore key_req_i this cycle
//   dat_mask_i      : ignore dat_req_i this cycle
//   grant_en_i      : caller accepts the grant this cycle (updates last_grant)
//   gnt_valid_o     : some eligible request present
//   gnt_o           : winning requester
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_rr_arb
    import aes_pkg::*;
#(
    parameter int KEY_PRIORITY = 0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   key_req_i,
    input  logic   dat_req_i,
    input  logic   key_mask_i,
    input  logic   dat_mask_i,
    input  logic   grant_en_i,
    output logic   gnt_valid_o,
    output grant_e gnt_o
);

    grant_e last_grant_q;
    logic   w_key_elig;
    logic   w_dat_elig;

    always_comb begin
        w_key_elig  = key_req_i & ~key_mask_i;
        w_dat_elig  = dat_req_i & ~dat_mask_i;
        gnt_valid_o = w_key_elig | w_dat_elig;
        gnt_o       = GNT_KEY;
        if (w_key_elig && w_dat_elig) begin
            if (KEY_PRIORITY != 0) begin
                gnt_o = GNT_KEY;
            end else begin
                gnt_o = (last_grant_q == GNT_DAT) ? GNT_KEY : GNT_DAT;
            end
        end else if (w_dat_elig) begin
            gnt_o = GNT_DAT;
        end
    end

    // Reset value DAT makes the key requester win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GNT_DAT;
        end else if (grant_en_i && gnt_valid_o) begin
            last_grant_q <= gnt_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sbox_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sbox_arbiter
// Description : Shares one 32-bit S-box lane group between the key scheduler
//               (one forward SubWord) and the datapath (one 128-bit state,
//               issued as four words on consecutive cycles). One transaction
//               at a time; results are registered and acked with a pulse.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : sbox_arbiter_if.slave - request/ack ports, S-box lane port, busy
// Parameters:
//   SBOX_LATENCY : lane latency from sbox_in to sbox_out_*, 1..3
//   KEY_PRIORITY : 0 = round-robin on a tie, 1 = key always wins a tie
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_arbiter
    import aes_pkg::*;
#(
    parameter int SBOX_LATENCY = 1,
    parameter int KEY_PRIORITY = 0
) (
    input  logic           clk,
    input  logic           rst,
    sbox_arbiter_if.slave  bus
);

    localparam logic [1:0] c_DRAIN_LAST = 2'(SBOX_LATENCY - 1);

    state_e       state_q;
    grant_e       txn_q;
    logic [1:0]   wc_q;
    logic [1:0]   drain_q;
    logic [127:0] dat_state_q;
    logic [31:0]  sbox_in_q;
    logic         sbox_enc_q;
    logic         key_ack_q;
    logic         dat_ack_q;
    logic         busy_q;
    logic         key_mask_q;
    logic         dat_mask_q;

    logic         w_gnt_valid;
    grant_e       w_gnt;

    sbox_rr_arb #(
        .KEY_PRIORITY (KEY_PRIORITY)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .key_req_i   (bus.key_req),
        .dat_req_i   (bus.dat_req),
        .key_mask_i  (key_mask_q),
        .dat_mask_i  (dat_mask_q),
        .grant_en_i  (state_q == S_IDLE),
        .gnt_valid_o (w_gnt_valid),
        .gnt_o       (w_gnt)
    );

    // ------------------------------------------------------------------
    // Control FSM. All outputs it drives are registered.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            txn_q       <= GNT_DAT;
            wc_q        <= c_WC_FIRST;
            drain_q     <= 2'd0;
            dat_state_q <= '0;
            sbox_in_q   <= '0;
            sbox_enc_q  <= 1'b1;
            key_ack_q   <= 1'b0;
            dat_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
            key_mask_q  <= 1'b0;
            dat_mask_q  <= 1'b0;
        end else begin
            key_ack_q  <= 1'b0;
            dat_ack_q  <= 1'b0;
            key_mask_q <= 1'b0;
            dat_mask_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_gnt_valid) begin
                        busy_q <= 1'b1;
                        txn_q  <= w_gnt;
                        if (w_gnt == GNT_KEY) begin
                            state_q    <= S_KEY_ISSUE;
                            sbox_in_q  <= bus.key_word;
                            sbox_enc_q <= 1'b1;
                        end else begin
                            state_q     <= S_DAT_ISSUE;
                            dat_state_q <= bus.dat_state;
                            wc_q        <= c_WC_FIRST;
                            sbox_in_q   <= state_word(bus.dat_state, c_WC_FIRST);
                            sbox_enc_q  <= bus.dat_enc_dec;
                        end
                    end
                end
                S_KEY_ISSUE: begin
                    state_q    <= S_DRAIN;
                    drain_q    <= 2'd0;
                    sbox_in_q  <= '0;
                    sbox_enc_q <= 1'b1;
                end
                S_DAT_ISSUE: begin
                    if (wc_q == c_WC_LAST) begin
                        state_q    <= S_DRAIN;
                        drain_q    <= 2'd0;
                        sbox_in_q  <= '0;
                        sbox_enc_q <= 1'b1;
                    end else begin
                        wc_q      <= wc_q + 2'd1;
                        sbox_in_q <= state_word(dat_state_q, wc_q + 2'd1);
                    end
                end
                S_DRAIN: begin
                    // The last issued word retires on this same edge, so the
                    // result registers and the ack pulse appear together.
                    if (drain_q == c_DRAIN_LAST) begin
                        state_q   <= S_ACK;
                        key_ack_q <= (txn_q == GNT_KEY);
                        dat_ack_q <= (txn_q == GNT_DAT);
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    // The requester just acknowledged may not have dropped
                    // its level request yet; keep it out of the next decision.
                    key_mask_q <= (txn_q == GNT_KEY);
                    dat_mask_q <= (txn_q == GNT_DAT);
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // In-flight tracker: one entry per issued word, shifted in lock-step
    // with the lane pipeline. The entry leaving the last stage tells which
    // lane output to take and where to store it.
    // ------------------------------------------------------------------
    trk_t        trk_q [SBOX_LATENCY];
    trk_t        w_push;
    trk_t        w_ret;
    logic [31:0] w_lane;
    logic [95:0] shadow_q;
    logic [31:0] key_result_q;
    logic [127:0] dat_result_q;

    always_comb begin
        w_push        = '0;
        w_push.valid  = (state_q == S_KEY_ISSUE) || (state_q == S_DAT_ISSUE);
        w_push.is_dat = (state_q == S_DAT_ISSUE);
        w_push.enc    = sbox_enc_q;
        w_push.idx    = (state_q == S_DAT_ISSUE) ? wc_q : c_WC_FIRST;
        w_ret         = trk_q[SBOX_LATENCY-1];
        w_lane        = w_ret.enc ? bus.sbox_out_enc : bus.sbox_out_dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SBOX_LATENCY; i++) begin
                trk_q[i] <= '0;
            end
            shadow_q     <= '0;
            key_result_q <= '0;
            dat_result_q <= '0;
        end else begin
            trk_q[0] <= w_push;
            for (int i = SBOX_LATENCY - 1; i > 0; i--) begin
                trk_q[i] <= trk_q[i-1];
            end
            if (w_ret.valid) begin
                if (!w_ret.is_dat) begin
                    key_result_q <= w_lane;
                end else begin
                    // Words 0..2 collect in the shadow; the final word
                    // publishes the whole state at once.
                    case (w_ret.idx)
                        2'd0:    shadow_q[95:64] <= w_lane;
                        2'd1:    shadow_q[63:32] <= w_lane;
                        2'd2:    shadow_q[31:0]  <= w_lane;
                        default: dat_result_q    <= {shadow_q, w_lane};
                    endcase
                end
            end
        end
    end

    assign bus.sbox_in      = sbox_in_q;
    assign bus.sbox_enc_dec = sbox_enc_q;
    assign bus.key_ack      = key_ack_q;
    assign bus.dat_ack      = dat_ack_q;
    assign bus.key_result   = key_result_q;
    assign bus.dat_result   = dat_result_q;
    assign bus.busy         = busy_q;

endmodule
`default_nettype wire
